// File: rtl/mac_result_encoder.sv
// rtl/mac_result_encoder.sv - packs rounded/clamped MAC lane results into a 24-bit operand word
// Two-stage pipeline: S1 holds per-lane encoded fields, S2 holds the packed word and flags.
module mac_result_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_mode,
   input  logic [5:0]  in_sign,
   input  logic [59:0] in_exp,
   input  logic [71:0] in_man,
   input  logic [5:0]  in_zero,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [23:0] out_data,
   output logic [5:0]  out_sat,
   output logic [5:0]  out_flush,
   input  logic        clr_sts,
   output logic        sts_sat,
   output logic        sts_flush
);

   localparam logic [1:0] MODE_BF16 = 2'b00;
   localparam logic [1:0] MODE_E4M3 = 2'b01;
   localparam logic [1:0] MODE_E3M0 = 2'b10;
   localparam logic [1:0] MODE_INT4 = 2'b11;

   // Rounders return {sat, flush, sign, field}; the increment is added to {biased, fraction}
   // so a mantissa carry ripples into the exponent.
   function automatic logic [17:0] enc_bf16(input logic s, input logic [9:0] e,
                                            input logic [10:0] f, input logic z);
      logic signed [10:0] b;
      logic               inc;
      logic signed [18:0] v;
      logic [17:0]        r;
      b   = $signed({e[9], e}) + 11'sd127;
      inc = f[3] & ((|f[2:0]) | f[4]);
      v   = $signed({b[10], b, f[10:4]}) + $signed({18'd0, inc});
      if (z)
         r = {2'b00, s, 15'h0000};
      else if (v > 19'sd32639)
         r = {2'b10, s, 15'h7F7F};
      else if (v < 19'sd128)
         r = {2'b01, s, 15'h0000};
      else
         r = {2'b00, s, v[14:0]};
      return r;
   endfunction

   function automatic logic [9:0] enc_e4m3(input logic s, input logic [9:0] e,
                                           input logic [10:0] f, input logic z);
      logic signed [10:0] b;
      logic               inc;
      logic signed [14:0] v;
      logic [9:0]         r;
      b   = $signed({e[9], e}) + 11'sd7;
      inc = f[7] & ((|f[6:0]) | f[8]);
      v   = $signed({b[10], b, f[10:8]}) + $signed({14'd0, inc});
      if (z)
         r = {2'b00, s, 7'h00};
      else if (v > 15'sd126)
         r = {2'b10, s, 7'h7E};
      else if (v < 15'sd8)
         r = {2'b01, s, 7'h00};
      else
         r = {2'b00, s, v[6:0]};
      return r;
   endfunction

   // No mantissa bits are kept, so ties are broken on the exponent LSB.
   function automatic logic [5:0] enc_e3m0(input logic s, input logic [9:0] e,
                                           input logic [10:0] f, input logic z);
      logic signed [10:0] b;
      logic               inc;
      logic signed [11:0] v;
      logic [5:0]         r;
      b   = $signed({e[9], e}) + 11'sd3;
      inc = f[10] & ((|f[9:0]) | b[0]);
      v   = $signed({b[10], b}) + $signed({11'd0, inc});
      if (z)
         r = {2'b00, s, 3'b000};
      else if (v > 12'sd7)
         r = {2'b10, s, 3'b111};
      else if (v < 12'sd1)
         r = {2'b01, s, 3'b000};
      else
         r = {2'b00, s, v[2:0]};
      return r;
   endfunction

   function automatic logic [4:0] enc_int4(input logic [11:0] m, input logic z);
      logic signed [11:0] v;
      logic [4:0]         r;
      v = $signed(m);
      if (z)
         r = 5'b0_0000;
      else if (v > 12'sd7)
         r = 5'b1_0111;
      else if (v < -12'sd8)
         r = 5'b1_1000;
      else
         r = {1'b0, m[3:0]};
      return r;
   endfunction

   logic        en;
   logic [17:0] bf;
   logic [9:0]  e4 [0:2];
   logic [5:0]  e3 [0:5];
   logic [4:0]  i4 [0:5];
   logic [15:0] c_f0;
   logic [7:0]  c_f1, c_f2;
   logic [3:0]  c_f3, c_f4, c_f5;
   logic [5:0]  c_sat, c_flush;

   logic        s1_valid;
   logic [1:0]  s1_mode;
   logic [15:0] s1_f0;
   logic [7:0]  s1_f1, s1_f2;
   logic [3:0]  s1_f3, s1_f4, s1_f5;
   logic [5:0]  s1_sat, s1_flush;
   logic [23:0] packed_word;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   always_comb begin
      bf = enc_bf16(in_sign[0], in_exp[9:0], in_man[10:0], in_zero[0]);
      for (int k = 0; k < 3; k++)
         e4[k] = enc_e4m3(in_sign[k], in_exp[10*k +: 10], in_man[12*k +: 11], in_zero[k]);
      for (int k = 0; k < 6; k++) begin
         e3[k] = enc_e3m0(in_sign[k], in_exp[10*k +: 10], in_man[12*k +: 11], in_zero[k]);
         i4[k] = enc_int4(in_man[12*k +: 12], in_zero[k]);
      end
   end

   // Lanes outside the active mode keep their zero defaults, which zeroes their bits and flags.
   always_comb begin
      c_f0    = 16'h0000;
      c_f1    = 8'h00;
      c_f2    = 8'h00;
      c_f3    = 4'h0;
      c_f4    = 4'h0;
      c_f5    = 4'h0;
      c_sat   = 6'b000000;
      c_flush = 6'b000000;
      case (in_mode)
         MODE_BF16: {c_sat[0], c_flush[0], c_f0} = bf;
         MODE_E4M3: begin
            {c_sat[0], c_flush[0], c_f0[7:0]} = e4[0];
            {c_sat[1], c_flush[1], c_f1}      = e4[1];
            {c_sat[2], c_flush[2], c_f2}      = e4[2];
         end
         MODE_E3M0: begin
            {c_sat[0], c_flush[0], c_f0[3:0]} = e3[0];
            {c_sat[1], c_flush[1], c_f1[3:0]} = e3[1];
            {c_sat[2], c_flush[2], c_f2[3:0]} = e3[2];
            {c_sat[3], c_flush[3], c_f3}      = e3[3];
            {c_sat[4], c_flush[4], c_f4}      = e3[4];
            {c_sat[5], c_flush[5], c_f5}      = e3[5];
         end
         MODE_INT4: begin
            {c_sat[0], c_f0[3:0]} = i4[0];
            {c_sat[1], c_f1[3:0]} = i4[1];
            {c_sat[2], c_f2[3:0]} = i4[2];
            {c_sat[3], c_f3}      = i4[3];
            {c_sat[4], c_f4}      = i4[4];
            {c_sat[5], c_f5}      = i4[5];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_mode  <= MODE_BF16;
         s1_f0    <= 16'h0000;
         s1_f1    <= 8'h00;
         s1_f2    <= 8'h00;
         s1_f3    <= 4'h0;
         s1_f4    <= 4'h0;
         s1_f5    <= 4'h0;
         s1_sat   <= 6'b000000;
         s1_flush <= 6'b000000;
      end else if (en) begin
         s1_valid <= in_valid;
         s1_mode  <= in_mode;
         s1_f0    <= c_f0;
         s1_f1    <= c_f1;
         s1_f2    <= c_f2;
         s1_f3    <= c_f3;
         s1_f4    <= c_f4;
         s1_f5    <= c_f5;
         s1_sat   <= c_sat;
         s1_flush <= c_flush;
      end
   end

   always_comb begin
      packed_word = 24'h000000;
      case (s1_mode)
         MODE_BF16: packed_word = {8'h00, s1_f0};
         MODE_E4M3: packed_word = {s1_f0[7:0], s1_f1, s1_f2};
         default:   packed_word = {s1_f0[3:0], s1_f1[3:0], s1_f2[3:0], s1_f3, s1_f4, s1_f5};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= 24'h000000;
         out_sat   <= 6'b000000;
         out_flush <= 6'b000000;
      end else if (en) begin
         out_valid <= s1_valid;
         out_data  <= s1_valid ? packed_word : 24'h000000;
         out_sat   <= s1_valid ? s1_sat : 6'b000000;
         out_flush <= s1_valid ? s1_flush : 6'b000000;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sts_sat   <= 1'b0;
         sts_flush <= 1'b0;
      end else if (clr_sts) begin
         sts_sat   <= 1'b0;
         sts_flush <= 1'b0;
      end else if (out_valid && out_ready) begin
         sts_sat   <= sts_sat | (|out_sat);
         sts_flush <= sts_flush | (|out_flush);
      end
   end

endmodule

// File: tb/tb_mac_result_encoder.sv
// tb/tb_mac_result_encoder.sv - self-checking bench for mac_result_encoder
// Arithmetic reference model plus scoreboard, checked every negedge; directed literals pin the model.
module tb_mac_result_encoder;

   logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, clr_sts, sts_sat, sts_flush;
   logic [1:0]  in_mode;
   logic [5:0]  in_sign, in_zero, out_sat, out_flush;
   logic [59:0] in_exp;
   logic [71:0] in_man;
   logic [23:0] out_data;

   mac_result_encoder dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_zero(in_zero),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
      .out_flush(out_flush), .clr_sts(clr_sts), .sts_sat(sts_sat), .sts_flush(sts_flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] data;
      logic [5:0]  sat, flush;
      bit          has_lit;
      logic [23:0] ld;
      logic [5:0]  ls, lf;
      int          acc, stl;
   } ent_t;

   ent_t        q[$];
   ent_t        me;
   int          n_chk = 0, n_fail = 0;
   int          cyc = 0, stalls = 0, rdone = 0;
   bit          cur_hl = 0;
   logic [23:0] cur_ld = 0;
   logic [5:0]  cur_ls = 0, cur_lf = 0;
   bit          m_ssat = 0, m_sflush = 0, prev_ov = 0, prev_hs = 0, hs;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Value-level model: quantise the fraction, round half-to-even, then range-check the result.
   function automatic void model(input logic [1:0] mode, input logic [5:0] sg, input logic [59:0] ex,
                                 input logic [71:0] mn, input logic [5:0] zr,
                                 output logic [23:0] d, output logic [5:0] st, output logic [5:0] fl);
      int nl, F, bias, maxv, fw, pos, field, frac, sh, kept, rem, half, biased, lsb, inc, val, mag, e;
      logic signed [9:0]  es;
      logic signed [11:0] ms;
      d = 0; st = 0; fl = 0;
      nl = (mode == 0) ? 1 : (mode == 1) ? 3 : 6;
      case (mode)
         2'd0:    begin F = 7; bias = 127; maxv = 254 * 128 + 127; fw = 15; end
         2'd1:    begin F = 3; bias = 7;   maxv = 15 * 8 + 6;      fw = 7;  end
         default: begin F = 0; bias = 3;   maxv = 7;               fw = 3;  end
      endcase
      for (int k = 0; k < nl; k++) begin
         pos = (mode == 0) ? 0 : (mode == 1) ? 16 - 8 * k : 20 - 4 * k;
         if (mode == 3) begin
            ms = mn[12*k +: 12];
            if (zr[k]) field = 0;
            else if (ms > 7) begin field = 7; st[k] = 1; end
            else if (ms < -8) begin field = 8; st[k] = 1; end
            else field = int'(ms) & 15;
         end else if (zr[k]) begin
            field = int'(sg[k]) << fw;
         end else begin
            es = ex[10*k +: 10];
            e = es;
            frac = int'(mn[12*k +: 11]);
            sh = 11 - F;
            kept = frac >> sh;
            rem = frac % (1 << sh);
            half = 1 << (sh - 1);
            biased = e + bias;
            lsb = (F > 0) ? kept % 2 : biased & 1;
            inc = (rem > half || (rem == half && lsb == 1)) ? 1 : 0;
            val = biased * (1 << F) + kept + inc;
            if (val > maxv) begin mag = maxv; st[k] = 1; end
            else if (val < (1 << F)) begin mag = 0; fl[k] = 1; end
            else mag = val;
            field = (int'(sg[k]) << fw) | mag;
         end
         d = d | (24'(field) << pos);
      end
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_ssat = 0; m_sflush = 0; prev_ov = 0; prev_hs = 0;
      end else begin
         cyc++;
         hs = 0;
         check("in_ready", {31'd0, in_ready}, {31'd0, !out_valid || out_ready});
         check("sts_sat", {31'd0, sts_sat}, {31'd0, m_ssat});
         check("sts_flush", {31'd0, sts_flush}, {31'd0, m_sflush});
         if (out_valid) begin
            if (q.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               check("out_data", {8'd0, out_data}, {8'd0, q[0].data});
               check("out_sat", {26'd0, out_sat}, {26'd0, q[0].sat});
               check("out_flush", {26'd0, out_flush}, {26'd0, q[0].flush});
               if (!prev_ov || prev_hs) begin
                  if (q[0].has_lit) begin
                     check("model_data", {8'd0, q[0].data}, {8'd0, q[0].ld});
                     check("model_sat", {26'd0, q[0].sat}, {26'd0, q[0].ls});
                     check("model_flush", {26'd0, q[0].flush}, {26'd0, q[0].lf});
                  end
                  if (stalls == q[0].stl) check("latency", cyc - q[0].acc, 2);
               end
               if (out_ready) begin
                  hs = 1;
                  me = q.pop_front();
               end else begin
                  stalls++;
               end
            end
         end
         if (clr_sts) begin
            m_ssat = 0; m_sflush = 0;
         end else if (hs) begin
            m_ssat = m_ssat | (|me.sat);
            m_sflush = m_sflush | (|me.flush);
         end
         if (in_valid && in_ready) begin
            model(in_mode, in_sign, in_exp, in_man, in_zero, me.data, me.sat, me.flush);
            me.has_lit = cur_hl; me.ld = cur_ld; me.ls = cur_ls; me.lf = cur_lf;
            me.acc = cyc; me.stl = stalls;
            q.push_back(me);
         end
         prev_ov = out_valid;
         prev_hs = hs;
      end
   end

   task automatic clear(input int mode);
      in_mode = 2'(mode); in_sign = 0; in_exp = 0; in_man = 0; in_zero = 0;
   endtask

   task automatic lane(input int k, input bit s, input int e, input int m, input bit z);
      in_sign[k] = s;
      in_exp[10*k +: 10] = 10'(e);
      in_man[12*k +: 12] = 12'(m);
      in_zero[k] = z;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input bit hl, input logic [23:0] ld, input logic [5:0] ls, input logic [5:0] lf);
      bit acc, ok;
      ok = 0;
      cur_hl = hl; cur_ld = ld; cur_ls = ls; cur_lf = lf;
      in_valid = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) begin ok = 1; break; end
      end
      if (!ok) check("send_timeout", 0, 1);
      in_valid = 0;
      cur_hl = 0;
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (q.size() == 0 && !out_valid) begin ok = 1; break; end
      end
      check("drain", {31'd0, ok}, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_word();
      int md;
      md = int'($urandom_range(0, 3));
      clear(md);
      for (int k = 0; k < 6; k++)
         lane(k, 1'($urandom), ($urandom % 6 == 0) ? int'($urandom_range(0, 280)) - 140
                                                   : int'($urandom_range(0, 24)) - 12,
              int'($urandom % 4096) | ((md != 3) ? 2048 : 0), ($urandom % 10 == 0));
   endtask

   initial begin
      clk = 0; rst_n = 0; in_valid = 0; out_ready = 0; clr_sts = 0;
      clear(0);
      idle(3);
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out_data", {8'd0, out_data}, 0);
      check("rst_out_sat", {26'd0, out_sat}, 0);
      check("rst_out_flush", {26'd0, out_flush}, 0);
      check("rst_sts", {30'd0, sts_sat, sts_flush}, 0);
      check("rst_in_ready", {31'd0, in_ready}, 1);
      rst_n = 1; out_ready = 1;

      clear(0); lane(0, 0, 0, 'h800, 0); lane(1, 0, 200, 'hFFF, 0);
      send(1, 24'h003F80, 6'b000000, 6'b000000);
      clear(0); lane(0, 1, 128, 'h800, 0);
      send(1, 24'h00FF7F, 6'b000001, 6'b000000);
      clear(1); lane(0, 0, 0, 'h880, 0); lane(1, 0, 0, 'h980, 0); lane(2, 0, 0, 'hC00, 0);
      lane(3, 1, 300, 'hFFF, 0);
      send(1, 24'h383A3C, 6'b000000, 6'b000000);
      idle(2);
      clear(1); lane(0, 0, 8, 'hF00, 0); lane(1, 1, -7, 'h800, 0); lane(2, 0, 50, 'hFFF, 1);
      send(1, 24'h7E8000, 6'b000001, 6'b000010);
      clear(1); lane(0, 0, 0, 'hFFF, 0); lane(1, 0, -7, 'hF80, 0); lane(2, 0, 8, 'hE00, 0);
      send(1, 24'h40087E, 6'b000000, 6'b000000);
      clear(2);
      for (int k = 0; k < 6; k++) lane(k, 0, 0, 'hC00, 0);
      send(1, 24'h444444, 6'b000000, 6'b000000);
      clear(3); lane(0, 0, 0, 7, 0); lane(1, 0, 0, 8, 0); lane(2, 0, 0, 'hFF8, 0);
      lane(3, 0, 0, 'hFF7, 0); lane(4, 0, 0, 0, 0); lane(5, 0, 0, 'hFFF, 0);
      send(1, 24'h77880F, 6'b001010, 6'b000000);
      drain();
      check("sticky_sat_set", {31'd0, sts_sat}, 1);
      check("sticky_flush_set", {31'd0, sts_flush}, 1);
      clr_sts = 1;
      idle(1);
      clr_sts = 0;
      check("sticky_cleared", {30'd0, sts_sat, sts_flush}, 0);

      fork
         begin
            for (int i = 0; i < 4; i++) begin
               clear(i % 4);
               for (int k = 0; k < 6; k++) lane(k, 1'(i + k), i * 3 - 4 + k, 'h900 + i * 37 + k * 101, 0);
               send(0, 0, 0, 0);
            end
         end
         begin
            @(posedge clk);
            @(posedge clk);
            #1 out_ready = 0;
            #1 check("stall_in_ready", {31'd0, in_ready}, 0);
            repeat (3) @(posedge clk);
            #1 out_ready = 1;
         end
      join
      drain();

      rdone = 0;
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               rand_word();
               send(0, 0, 0, 0);
               if ($urandom % 4 == 0) idle(1);
            end
            rdone = 1;
         end
         begin
            while (!rdone) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom % 3 != 0);
               clr_sts = ($urandom % 12 == 0);
            end
            clr_sts = 0;
            out_ready = 1;
         end
      join
      drain();

      clear(0); lane(0, 1, 128, 'h800, 0);
      send(1, 24'h00FF7F, 6'b000001, 6'b000000);
      drain();
      check("pre_reset_sticky", {31'd0, sts_sat}, 1);
      out_ready = 0;
      clear(1); lane(0, 0, 1, 'hA00, 0); send(0, 0, 0, 0);
      clear(2); lane(0, 0, 2, 'h900, 0); send(0, 0, 0, 0);
      @(posedge clk);
      #3 rst_n = 0;
      #1;
      check("async_rst_valid", {31'd0, out_valid}, 0);
      check("async_rst_data", {8'd0, out_data}, 0);
      check("async_rst_sticky", {30'd0, sts_sat, sts_flush}, 0);
      q.delete();
      idle(2);
      rst_n = 1; out_ready = 1;
      clear(2);
      for (int k = 0; k < 6; k++) lane(k, 0, 0, 'hC00, 0);
      send(1, 24'h444444, 6'b000000, 6'b000000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
